cache_fill_fsm: RTL

Miss-handling initiator for the byte-addressable, 16-bit multi-cycle memory. The memory accepts single-cycle writes and returns read data with a fixed 4-cycle pipelined latency, flagged by its data_valid output. On a cache miss this block issues 8 back-to-back word reads for the 16-byte block, collects the returning words into the cache data array, and writes the tag after the last word. When idle it also forwards single-cycle store write-throughs to memory. It sits between the I/D cache controllers and the memory instance.

---
 rtl/cache_fill_fsm_pkg.sv | 15 +
 rtl/cache_fill_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM states and block geometry.
// Reused by the cache controllers, the tag array and the fill FSM.
package cache_fill_fsm_pkg;

    localparam int unsigned BLOCK_WORDS       = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WORD_IDX_BITS     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm.sv
// Cache miss fill initiator.
// On a miss, issues BLOCK_WORDS back-to-back word reads for the 16-byte block,
// writes each returning word into the data array and writes the tag with the
// last word. While idle it forwards single-cycle store write-throughs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   miss_detected/miss_address miss request (level, sampled in IDLE)
//   store_req/addr/data        write-through request (level, sampled in IDLE)
//   mem_data_out/valid         read return from memory
//   mem_en/wr/addr/wdata       memory command (combinational from state/inputs)
//   fsm_busy, store_ack        pipeline stall, store accepted this cycle
//   write_data_array, write_tag_array, fill_word_idx, fill_data  array writes
module cache_fill_fsm #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = cache_fill_fsm_pkg::BLOCK_WORDS,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  store_req,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [15:0]           store_data,
    input  logic [15:0]           mem_data_out,
    input  logic                  mem_data_valid,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  fsm_busy,
    output logic                  store_ack,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [2:0]            fill_word_idx,
    output logic [15:0]           fill_data
);

    import cache_fill_fsm_pkg::*;

    localparam int unsigned AGE_BITS = 3;
    localparam logic [WORD_IDX_BITS-1:0] LAST_IDX   = WORD_IDX_BITS'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0]    BLOCK_MASK = ~ADDR_WIDTH'(2**BLOCK_OFFSET_BITS - 1);

    fill_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [WORD_IDX_BITS-1:0]  issue_cnt_q, issue_cnt_d;
    logic [WORD_IDX_BITS-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [AGE_BITS-1:0]       rst_age_q;

    // State, block base and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
        end
    end

    // Cycles since reset release, saturating; lets late read returns of an
    // abandoned fill drain out after a reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_age_q <= '0;
        end else if (rst_age_q != {AGE_BITS{1'b1}}) begin
            rst_age_q <= rst_age_q + AGE_BITS'(1);
        end
    end

    // Next state and outputs; everything is held at 0 while reset is asserted
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        fsm_busy         = 1'b0;
        store_ack        = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word_idx    = '0;
        fill_data        = '0;

        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    // A miss wins over a simultaneous store
                    if (miss_detected) begin
                        base_d      = miss_address & BLOCK_MASK;
                        issue_cnt_d = '0;
                        rcv_cnt_d   = '0;
                        state_d     = ISSUE;
                    end else if (store_req) begin
                        mem_en    = 1'b1;
                        mem_wr    = 1'b1;
                        mem_addr  = store_addr;
                        mem_wdata = store_data;
                        store_ack = 1'b1;
                    end
                end
                ISSUE: begin
                    // Word offset is OR-ed in, so no carry leaves the block
                    mem_en   = 1'b1;
                    mem_addr = base_q | ADDR_WIDTH'({issue_cnt_q, 1'b0});
                    if (issue_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + WORD_IDX_BITS'(1);
                    end
                end
                DRAIN: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Receive path: returns may overlap the issue phase
            if (state_q != IDLE) begin
                fsm_busy = 1'b1;
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word_idx    = rcv_cnt_q;
                    fill_data        = mem_data_out;
                    if (rcv_cnt_q == LAST_IDX) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        rcv_cnt_d = rcv_cnt_q + WORD_IDX_BITS'(1);
                    end
                end
            end
        end
    end

    // Read data in IDLE is only legal as leftovers of a fill cut by reset
    a_no_stray_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE && mem_data_valid) |-> (32'(rst_age_q) < MEM_LATENCY));

    // Cannot receive more words than were requested
    a_rcv_le_issue: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ISSUE) |-> (rcv_cnt_q <= issue_cnt_q));

endmodule
